// File: rtl/iobus_arbiter.sv
// iobus_arbiter: shares the single OTTER MMIO bus between two masters.
// Accesses are serialised round-robin. A master may lock the bus for a
// bounded run of consecutive accesses. Each access holds the bus for
// ACC_CYCLES cycles and then spends one DONE cycle returning registered
// read data. Every output decodes from registered state and owner.
`timescale 1ns/1ps
module iobus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int ACC_CYCLES = 1,
  parameter int LOCK_MAX   = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          M0_REQ,
  input  logic          M1_REQ,
  input  logic          M0_WR,
  input  logic          M1_WR,
  input  logic          M0_LOCK,
  input  logic          M1_LOCK,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [DW-1:0] M0_WDATA,
  input  logic [DW-1:0] M1_WDATA,
  output logic          M0_GNT,
  output logic          M1_GNT,
  output logic          M0_DONE,
  output logic          M1_DONE,
  output logic [DW-1:0] M0_RDATA,
  output logic [DW-1:0] M1_RDATA,
  output logic [AW-1:0] IOBUS_ADDR,
  output logic [DW-1:0] IOBUS_OUT,
  output logic          IOBUS_WR,
  input  logic [DW-1:0] IOBUS_IN
);

  // A counter must hold either the access length or the lock run length.
  localparam int CNT_MAX = (ACC_CYCLES > LOCK_MAX) ? ACC_CYCLES : LOCK_MAX;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] ACC_LAST = CW'(ACC_CYCLES - 1);
  localparam logic [CW:0]   LOCK_LIM = (CW+1)'(LOCK_MAX);

  logic [1:0]    state_r;
  logic          owner_r;
  logic          last_r;
  logic [CW-1:0] acc_cnt_r;
  logic [CW-1:0] lock_cnt_r;
  logic [DW-1:0] m0_rdata_r;
  logic [DW-1:0] m1_rdata_r;

  logic [1:0]    state_s;
  logic          owner_s;
  logic          last_s;
  logic [CW-1:0] acc_cnt_s;
  logic [CW-1:0] lock_cnt_s;

  logic          own_req_s;
  logic          own_lock_s;
  logic          own_wr_s;
  logic [AW-1:0] own_addr_s;
  logic [DW-1:0] own_wdata_s;
  logic          oth_req_s;

  logic          in_acc_s;
  logic          in_done_s;
  logic          final_s;
  logic          idle_win_s;
  logic [CW:0]   lock_inc_s;
  logic          lock_ok_s;
  logic [CW-1:0] lock_sat_s;

  assign in_acc_s  = (state_r == ST_ACC);
  assign in_done_s = (state_r == ST_DONE);
  assign final_s   = in_acc_s && (acc_cnt_r == ACC_LAST);

  // On a tie from idle the master that did not go last wins.
  assign idle_win_s = (M0_REQ && M1_REQ) ? ~last_r : M1_REQ;

  // Lock run check is done one bit wider so the +1 never wraps.
  assign lock_inc_s = {1'b0, lock_cnt_r} + {1'b0, CNT_ONE};
  assign lock_ok_s  = (lock_inc_s < LOCK_LIM);
  assign lock_sat_s = (lock_cnt_r == CNT_SAT) ? lock_cnt_r : lock_inc_s[CW-1:0];

  // Present the current owner's request port and the other master's request.
  always_comb begin
    if (owner_r) begin
      own_req_s   = M1_REQ;
      own_lock_s  = M1_LOCK;
      own_wr_s    = M1_WR;
      own_addr_s  = M1_ADDR;
      own_wdata_s = M1_WDATA;
      oth_req_s   = M0_REQ;
    end else begin
      own_req_s   = M0_REQ;
      own_lock_s  = M0_LOCK;
      own_wr_s    = M0_WR;
      own_addr_s  = M0_ADDR;
      own_wdata_s = M0_WDATA;
      oth_req_s   = M1_REQ;
    end
  end

  // Arbitration and access sequencing: IDLE -> ACC (ACC_CYCLES) -> DONE.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    last_s     = last_r;
    acc_cnt_s  = acc_cnt_r;
    lock_cnt_s = lock_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (M0_REQ || M1_REQ) begin
          state_s    = ST_ACC;
          owner_s    = idle_win_s;
          last_s     = idle_win_s;
          acc_cnt_s  = CNT_ZERO;
          lock_cnt_s = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        // Requests are ignored here: a started access always completes.
        acc_cnt_s = acc_cnt_r + CNT_ONE;
        if (final_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_DONE: begin
        if (own_lock_s && own_req_s && (lock_ok_s || !oth_req_s)) begin
          // Locked continuation; only contention ends the run at LOCK_MAX.
          state_s    = ST_ACC;
          acc_cnt_s  = CNT_ZERO;
          lock_cnt_s = lock_sat_s;
        end else if (oth_req_s) begin
          // Handover goes straight to ACC with no idle cycle.
          state_s    = ST_ACC;
          owner_s    = ~owner_r;
          last_s     = ~owner_r;
          acc_cnt_s  = CNT_ZERO;
          lock_cnt_s = CNT_ZERO;
        end else if (own_req_s) begin
          state_s    = ST_ACC;
          acc_cnt_s  = CNT_ZERO;
          lock_cnt_s = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        owner_s    = 1'b0;
        last_s     = 1'b1;
        acc_cnt_s  = CNT_ZERO;
        lock_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // Control state registers; last starts at 1 so M0 wins the first tie.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      owner_r    <= 1'b0;
      last_r     <= 1'b1;
      acc_cnt_r  <= CNT_ZERO;
      lock_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      last_r     <= last_s;
      acc_cnt_r  <= acc_cnt_s;
      lock_cnt_r <= lock_cnt_s;
    end
  end

  // Capture bus read data for the owner in the final access cycle (writes too).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m0_rdata_r <= {DW{1'b0}};
      m1_rdata_r <= {DW{1'b0}};
    end else if (final_s && owner_r) begin
      m1_rdata_r <= IOBUS_IN;
    end else if (final_s) begin
      m0_rdata_r <= IOBUS_IN;
    end else begin
      m0_rdata_r <= m0_rdata_r;
      m1_rdata_r <= m1_rdata_r;
    end
  end

  assign M0_GNT   = (in_acc_s || in_done_s) && !owner_r;
  assign M1_GNT   = (in_acc_s || in_done_s) &&  owner_r;
  assign M0_DONE  = in_done_s && !owner_r;
  assign M1_DONE  = in_done_s &&  owner_r;
  assign M0_RDATA = m0_rdata_r;
  assign M1_RDATA = m1_rdata_r;

  // The bus is driven only while an access is in progress.
  assign IOBUS_ADDR = in_acc_s ? own_addr_s  : {AW{1'b0}};
  assign IOBUS_OUT  = in_acc_s ? own_wdata_s : {DW{1'b0}};
  assign IOBUS_WR   = final_s && own_wr_s;

endmodule

// File: tb/tb_iobus_arbiter.sv
// Testbench for iobus_arbiter: three instances with different access and
// lock lengths, driven by queue-based masters and checked every cycle
// against a transaction-level reference model plus scenario checks.
`timescale 1ns/1ps
module tb_iobus_arbiter;

  localparam int ND = 3;

  function automatic int acc_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int lock_of(input int d);
    case (d)
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  typedef struct packed {
    logic        w;
    logic        l;
    logic [31:0] a;
    logic [31:0] wd;
  } acc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req   [ND][2];
  logic        wr    [ND][2];
  logic        lock  [ND][2];
  logic [31:0] addr  [ND][2];
  logic [31:0] wdata [ND][2];
  logic [31:0] bus_in [ND];
  logic        gnt   [ND][2];
  logic        done  [ND][2];
  logic [31:0] rdata [ND][2];
  logic [31:0] bus_addr [ND];
  logic [31:0] bus_out  [ND];
  logic        bus_wr   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int ACC_G  = acc_of(g);
    localparam int LOCK_G = lock_of(g);
    iobus_arbiter #(.AW(32), .DW(32), .ACC_CYCLES(ACC_G), .LOCK_MAX(LOCK_G)) u_dut (
      .CLK(clk), .RST_N(rst_n),
      .M0_REQ(req[g][0]), .M1_REQ(req[g][1]),
      .M0_WR(wr[g][0]), .M1_WR(wr[g][1]),
      .M0_LOCK(lock[g][0]), .M1_LOCK(lock[g][1]),
      .M0_ADDR(addr[g][0]), .M1_ADDR(addr[g][1]),
      .M0_WDATA(wdata[g][0]), .M1_WDATA(wdata[g][1]),
      .M0_GNT(gnt[g][0]), .M1_GNT(gnt[g][1]),
      .M0_DONE(done[g][0]), .M1_DONE(done[g][1]),
      .M0_RDATA(rdata[g][0]), .M1_RDATA(rdata[g][1]),
      .IOBUS_ADDR(bus_addr[g]), .IOBUS_OUT(bus_out[g]),
      .IOBUS_WR(bus_wr[g]), .IOBUS_IN(bus_in[g])
    );
  end

  int tests;
  int fails;
  int cyc;

  // Reference model: who holds the bus, how far into the access window it
  // is (ACC_CYCLES access cycles then one completion cycle), the length of
  // the current locked run, who went last, and the expected read returns.
  int          m_own    [ND];
  int          m_age    [ND];
  int          m_streak [ND];
  int          m_last   [ND];
  logic [31:0] m_rdata  [ND][2];

  acc_t q0[$];
  acc_t q1[$];
  logic hold_off [2];
  logic force_in;
  logic [31:0] force_val;

  logic [132:0] obs_v;
  logic [132:0] exp_v;
  logic [1:0]   o_gnt;
  logic [1:0]   o_done;
  logic         o_wr;
  logic [31:0]  o_addr;
  logic [31:0]  o_out;
  logic [31:0]  o_rd1;

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_own[d] = -1; m_age[d] = 0; m_streak[d] = 0; m_last[d] = 1;
      m_rdata[d][0] = 32'h0; m_rdata[d][1] = 32'h0;
    end
  endtask

  task automatic clear_stim();
    q0.delete(); q1.delete();
    hold_off[0] = 1'b0; hold_off[1] = 1'b0;
    force_in = 1'b0; force_val = 32'h0;
    for (int d = 0; d < ND; d++) begin
      bus_in[d] = 32'h0;
      for (int i = 0; i < 2; i++) begin
        req[d][i] = 1'b0; wr[d][i] = 1'b0; lock[d][i] = 1'b0;
        addr[d][i] = 32'h0; wdata[d][i] = 32'h0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_stim();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic acc_t rand_acc(input logic allow_lock);
    acc_t t;
    t.w  = 1'($urandom_range(1, 0));
    t.l  = allow_lock ? 1'($urandom_range(1, 0)) : 1'b0;
    t.a  = $urandom();
    t.wd = $urandom();
    return t;
  endfunction

  // One clock cycle on instance d: sample outputs and the model's
  // expectation, let the masters react, then advance the model.
  task automatic step(input int d);
    int a, o, p, w;
    logic [1:0] e_gnt, e_done;
    logic e_wr;
    logic [31:0] e_addr, e_out;
    acc_t h;
    @(negedge clk);
    a = acc_of(d);
    o = m_own[d];
    e_gnt = 2'b00; e_done = 2'b00; e_wr = 1'b0; e_addr = 32'h0; e_out = 32'h0;
    if (o >= 0) begin
      e_gnt[o] = 1'b1;
      if (m_age[d] == a) begin
        e_done[o] = 1'b1;
      end else begin
        e_addr = addr[d][o];
        e_out  = wdata[d][o];
        e_wr   = (m_age[d] == a - 1) && wr[d][o];
      end
    end
    o_gnt  = {gnt[d][1], gnt[d][0]};
    o_done = {done[d][1], done[d][0]};
    o_wr   = bus_wr[d];
    o_addr = bus_addr[d];
    o_out  = bus_out[d];
    o_rd1  = rdata[d][1];
    obs_v = {o_gnt, o_done, o_wr, o_addr, o_out, rdata[d][1], rdata[d][0]};
    exp_v = {e_gnt, e_done, e_wr, e_addr, e_out, m_rdata[d][1], m_rdata[d][0]};

    if (e_done[0] && q0.size() > 0) void'(q0.pop_front());
    if (e_done[1] && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin
      h = q0[0];
      req[d][0] = !hold_off[0]; wr[d][0] = h.w; lock[d][0] = h.l; addr[d][0] = h.a; wdata[d][0] = h.wd;
    end else begin
      req[d][0] = 1'b0; wr[d][0] = 1'b0; lock[d][0] = 1'b0; addr[d][0] = 32'h0; wdata[d][0] = 32'h0;
    end
    if (q1.size() > 0) begin
      h = q1[0];
      req[d][1] = !hold_off[1]; wr[d][1] = h.w; lock[d][1] = h.l; addr[d][1] = h.a; wdata[d][1] = h.wd;
    end else begin
      req[d][1] = 1'b0; wr[d][1] = 1'b0; lock[d][1] = 1'b0; addr[d][1] = 32'h0; wdata[d][1] = 32'h0;
    end
    bus_in[d] = force_in ? force_val : $urandom();

    if (m_own[d] < 0) begin
      if (req[d][0] || req[d][1]) begin
        w = (req[d][0] && req[d][1]) ? (1 - m_last[d]) : (req[d][1] ? 1 : 0);
        m_own[d] = w; m_last[d] = w; m_age[d] = 0; m_streak[d] = 0;
      end
    end else if (m_age[d] < a) begin
      if (m_age[d] == a - 1) m_rdata[d][m_own[d]] = bus_in[d];
      m_age[d] = m_age[d] + 1;
    end else begin
      o = m_own[d];
      p = 1 - o;
      if (lock[d][o] && req[d][o] && ((m_streak[d] + 1 < lock_of(d)) || !req[d][p])) begin
        m_age[d] = 0; m_streak[d] = m_streak[d] + 1;
      end else if (req[d][p]) begin
        m_own[d] = p; m_last[d] = p; m_age[d] = 0; m_streak[d] = 0;
      end else if (req[d][o]) begin
        m_age[d] = 0; m_streak[d] = 0;
      end else begin
        m_own[d] = -1;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    logic [132:0] r;
    rst_n = 1'b0;
    clear_stim();
    model_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      r = {gnt[d][1], gnt[d][0], done[d][1], done[d][0], bus_wr[d], bus_addr[d], bus_out[d], rdata[d][1], rdata[d][0]};
      if (r !== 133'd0) begin
        fails++; $display("FAIL reset_outputs dut=%0d got=%h exp=0", d, r);
      end
      tests++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(0);
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      tests++;
    end
  endtask

  task automatic test_write_single();
    int g_at, w_at, d_at, n_done, n_wr;
    logic [31:0] w_addr, w_out;
    acc_t t;
    g_at = -1; w_at = -1; d_at = -1; n_done = 0; n_wr = 0; w_addr = 32'h0; w_out = 32'h0;
    t.w = 1'b1; t.l = 1'b0; t.a = 32'h1108_0000; t.wd = 32'h0000_1234;
    q0.push_back(t);
    for (int k = 0; k < 5; k++) begin
      step(0);
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL write_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      tests++;
      if (o_gnt[0] && g_at < 0) g_at = k;
      if (o_wr) begin n_wr++; w_at = k; w_addr = o_addr; w_out = o_out; end
      if (o_done[0]) begin n_done++; d_at = k; end
    end
    if (g_at !== 1) begin fails++; $display("FAIL write_gnt_cycle got=%0d exp=1", g_at); end
    tests++;
    if (n_wr !== 1 || w_at !== 1) begin fails++; $display("FAIL write_wr_pulse got=%0d@%0d exp=1@1", n_wr, w_at); end
    tests++;
    if (w_addr !== 32'h1108_0000 || w_out !== 32'h0000_1234) begin
      fails++; $display("FAIL write_bus got=%h/%h exp=11080000/00001234", w_addr, w_out);
    end
    tests++;
    if (n_done !== 1 || d_at !== 2) begin fails++; $display("FAIL write_done got=%0d@%0d exp=1@2", n_done, d_at); end
    tests++;
    if (o_gnt !== 2'b00) begin fails++; $display("FAIL write_back_idle got=%b exp=00", o_gnt); end
    tests++;
  endtask

  task automatic test_round_robin();
    int order[$];
    int at[$];
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rand_acc(1'b0));
      q1.push_back(rand_acc(1'b0));
    end
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_own[0] >= 0) && k < 60) begin
      step(0);
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      tests++;
      if (o_done[0]) begin order.push_back(0); at.push_back(k); end
      if (o_done[1]) begin order.push_back(1); at.push_back(k); end
      k++;
    end
    if (k >= 60) begin fails++; $display("FAIL rr_timeout got=%0d cycles exp=<60", k); end
    tests++;
    if (order.size() !== 8) begin fails++; $display("FAIL rr_count got=%0d exp=8", order.size()); end
    tests++;
    for (int i = 0; i < order.size(); i++) begin
      if (order[i] !== (i % 2)) begin fails++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, order[i], i % 2); end
      tests++;
      if (i > 0) begin
        if (at[i] - at[i-1] !== 2) begin fails++; $display("FAIL rr_spacing idx=%0d got=%0d exp=2", i, at[i] - at[i-1]); end
        tests++;
      end
    end
  endtask

  task automatic test_lock();
    int m1_before, last_d1, first_g0, k;
    m1_before = 0; last_d1 = -1; first_g0 = -1;
    for (int i = 0; i < 6; i++) begin
      acc_t t;
      t = rand_acc(1'b0);
      t.l = 1'b1;
      q1.push_back(t);
    end
    q0.push_back(rand_acc(1'b0));
    q0.push_back(rand_acc(1'b0));
    hold_off[0] = 1'b1;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_own[0] >= 0) && k < 80) begin
      step(0);
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL lock_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      tests++;
      if (o_gnt[0] && first_g0 < 0) first_g0 = k;
      if (o_done[1] && first_g0 < 0) begin m1_before++; last_d1 = k; end
      if (k == 0) hold_off[0] = 1'b0;
      k++;
    end
    if (k >= 80) begin fails++; $display("FAIL lock_timeout got=%0d cycles exp=<80", k); end
    tests++;
    if (m1_before !== 4) begin fails++; $display("FAIL lock_run got=%0d exp=4", m1_before); end
    tests++;
    if (first_g0 !== last_d1 + 1) begin fails++; $display("FAIL lock_handover got=%0d exp=%0d", first_g0, last_d1 + 1); end
    tests++;
  endtask

  task automatic test_slow_read();
    int n_wr, d_at;
    logic [31:0] rd;
    acc_t t;
    n_wr = 0; d_at = -1; rd = 32'h0;
    force_in = 1'b1; force_val = 32'h0000_A5A5;
    t.w = 1'b0; t.l = 1'b0; t.a = 32'h1100_0000; t.wd = 32'h0;
    q1.push_back(t);
    for (int k = 0; k < 7; k++) begin
      step(1);
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL read_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      tests++;
      if (o_wr) n_wr++;
      if (o_done[1]) begin d_at = k; rd = o_rd1; end
    end
    force_in = 1'b0;
    if (n_wr !== 0) begin fails++; $display("FAIL read_no_wr got=%0d exp=0", n_wr); end
    tests++;
    if (d_at !== 4) begin fails++; $display("FAIL read_done_cycle got=%0d exp=4", d_at); end
    tests++;
    if (rd !== 32'h0000_A5A5) begin fails++; $display("FAIL read_rdata got=%h exp=0000a5a5", rd); end
    tests++;
  endtask

  task automatic test_drop_req();
    int n_done, d_at, n_wr;
    acc_t t;
    n_done = 0; d_at = -1; n_wr = 0;
    t = rand_acc(1'b0);
    t.w = 1'b1;
    q0.push_back(t);
    for (int k = 0; k < 8; k++) begin
      step(2);
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL drop_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      tests++;
      if (o_done[0]) begin n_done++; d_at = k; end
      if (o_wr) n_wr++;
      if (k == 0) hold_off[0] = 1'b1;
    end
    hold_off[0] = 1'b0;
    if (n_done !== 1 || d_at !== 3) begin fails++; $display("FAIL drop_done got=%0d@%0d exp=1@3", n_done, d_at); end
    tests++;
    if (n_wr !== 1) begin fails++; $display("FAIL drop_wr got=%0d exp=1", n_wr); end
    tests++;
  endtask

  task automatic test_reset_mid();
    acc_t t;
    logic [3:0] gd;
    t = rand_acc(1'b0);
    t.w = 1'b1;
    q0.push_back(t);
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      tests++;
    end
    if (o_wr !== 1'b1) begin fails++; $display("FAIL rstmid_pre_wr got=%b exp=1", o_wr); end
    tests++;
    rst_n = 1'b0;
    #1;
    gd = {gnt[1][1], gnt[1][0], done[1][1], done[1][0]};
    if (bus_wr[1] !== 1'b0 || bus_addr[1] !== 32'h0 || gd !== 4'b0) begin
      fails++; $display("FAIL rstmid_async got=wr%b addr%h gd%b exp=wr0 addr0 gd0", bus_wr[1], bus_addr[1], gd);
    end
    tests++;
    clear_stim();
    @(negedge clk);
    gd = {gnt[1][1], gnt[1][0], done[1][1], done[1][0]};
    if (gd !== 4'b0) begin fails++; $display("FAIL rstmid_hold got=%b exp=0000", gd); end
    tests++;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL rstmid_no_done cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      tests++;
    end
    q0.push_back(rand_acc(1'b0));
    q1.push_back(rand_acc(1'b0));
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL rstmid_tie_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      tests++;
      if (k == 1) begin
        if (o_gnt !== 2'b01) begin fails++; $display("FAIL rstmid_first_tie got=%b exp=01", o_gnt); end
        tests++;
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    int k;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 10; i++) begin
        q0.push_back(rand_acc(1'b1));
        q1.push_back(rand_acc(1'b1));
      end
      k = 0;
      while ((q0.size() > 0 || q1.size() > 0 || m_own[d] >= 0) && k < 400) begin
        step(d);
        if (obs_v !== exp_v) begin
          fails++; $display("FAIL random_model dut=%0d cyc=%0d got=%h exp=%h", d, cyc, obs_v, exp_v);
        end
        tests++;
        k++;
      end
      if (k >= 400) begin fails++; $display("FAIL random_timeout dut=%0d got=%0d exp=<400", d, k); end
      tests++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    test_reset();
    test_write_single();
    test_round_robin();
    test_lock();
    test_slow_read();
    test_drop_req();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
